mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the IF stage (instruction
//  fetch, read-only) and the MEM stage (load/store). Holds one outstanding
//  transaction at a time, forwards the winner's request, returns data/ack to it.
//  Sits between pipeIF/pipeMEM and the memory model; pipeIF's m_re/m_rack face this block.
// PARAMETERS
//  ADDR_L    32   address width
//  DATA_L    32   data width
//  STARVE_N  4    MEM grants in a row before IF is forced a grant (fixed-priority mode)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_re      in   1       IF read request, level, held until if_ack
//  if_addr    in   ADDR_L  IF read address
//  if_rlen    in   2       IF length code (0=1B,1=2B,3=4B; 2 illegal)
//  if_ack     out  1       one-cycle pulse, if_rdata valid same cycle
//  if_rdata   out  DATA_L  returned instruction word
//  mm_re      in   1       MEM read request, level, held until mm_ack
//  mm_we      in   1       MEM write request, level, held until mm_ack
//  mm_addr    in   ADDR_L  MEM address
//  mm_len     in   2       MEM length code, same encoding
//  mm_wdata   in   DATA_L  MEM store data
//  mm_ack     out  1       one-cycle pulse; mm_rdata valid same cycle on reads
//  mm_rdata   out  DATA_L  returned load data
//  m_re/m_we  out  1       memory read/write strobe, held until m_ack
//  m_addr     out  ADDR_L  registered address to memory
//  m_len      out  2       registered length code
//  m_wdata    out  DATA_L  registered store data
//  m_rdata    in   DATA_L  memory read data, valid with m_ack
//  m_ack      in   1       memory completion, one-cycle pulse
//  err        out  1       sticky: illegal len, re&we both high, or stray m_ack
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, starve counter 0, rr pointer = IF.
//  - FSM: IDLE -> BUSY_IF | BUSY_MM -> DONE -> IDLE.
//  - IDLE: sample requests; on grant latch addr/len/wdata/op into m_* regs and
//    raise m_re or m_we next edge. Latency request->strobe = 1 cycle.
//  - BUSY_x: strobes held; on m_ack latch m_rdata into x_rdata, drop strobe,
//    pulse x_ack for exactly one cycle (cycle after m_ack), go DONE.
//  - DONE: one dead cycle; winner's request is ignored, letting the requester
//    drop its level. Back-to-back requests from one port: min 4-cycle spacing.
//  - Arbitration (fixed): MEM beats IF; after STARVE_N consecutive MEM grants
//    with if_re pending, IF wins next; counter clears on any IF grant.
//  - mm_re & mm_we both high: err set, treated as write.
//  - Length code 2: err set, request still forwarded unchanged.
//  - m_ack while IDLE/DONE: ignored, err set. m_ack same cycle as grant: not possible
//    (strobe not yet up) -> treated as stray.
//  - Request dropped while BUSY: transaction completes, ack still pulsed.
//  - Reset mid-transaction: in-flight op abandoned, no ack, strobes cleared async.
//  - x_rdata holds last value between acks; never cleared except by reset.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; when both request in IDLE, the port not
//   granted last wins; STARVE_N and starve counter unused (compiled out).
//  ARB_RR_EN undefined: fixed MEM priority with STARVE_N anti-starvation.
// STRUCTURE
//  - Shared header mem_const.v: length codes LEN_B/LEN_H/LEN_W, FSM state
//    encodings ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_MM/ARB_DONE, port ids.
//  - Sub-module arb_pick: combinational winner select from (if_re, mm_req,
//    last/starve state); holds the ARB_RR_EN split. Rest is the FSM + regs.
// TESTING
//  1 Single IF read 0x1000, mem acks after 3 cycles with 0x00000013 ->
//    m_re at cycle 1, if_ack pulse 1 cycle after m_ack, if_rdata=0x13.
//  2 IF and MEM write (0x2000, 0xDEADBEEF, len 3) same cycle -> MEM first;
//    m_we, m_wdata=0xDEADBEEF; IF served after DONE.
//  3 Fixed mode, mm_re held 6 transactions, if_re held -> IF granted as 5th
//    grant (STARVE_N=4); RR build -> strict alternation MEM,IF,MEM,IF.
//  4 Stray m_ack in IDLE, then mm_len=2 -> err sets and stays 1 until rst.
//  5 rst pulsed while BUSY_MM with m_we high -> m_we 0 immediately,
//    no mm_ack, next if_re served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter.
// Holds length codes, FSM state encoding and requester port ids.
package mem_port_arbiter_pkg;

    localparam int unsigned LEN_L = 2;

    // Length codes: 1, 2 and 4 bytes; code 2 is reserved and flagged as illegal.
    localparam logic [LEN_L-1:0] LEN_B   = 2'd0;
    localparam logic [LEN_L-1:0] LEN_H   = 2'd1;
    localparam logic [LEN_L-1:0] LEN_ILL = 2'd2;
    localparam logic [LEN_L-1:0] LEN_W   = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_MM = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_MM = 1'b1
    } port_t;

    function automatic logic len_illegal(input logic [LEN_L-1:0] len);
        return len == LEN_ILL;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between the IF and MEM requesters.
// Config macro ARB_RR_EN: defined -> round-robin on last granted port;
// undefined -> MEM has priority unless the starvation limit is hit.
// Ports:
//   if_re       IF request pending
//   mm_req      MEM read or write pending
//   last_port   port granted most recently (round-robin build only)
//   starve_hit  IF has waited through the MEM grant limit (fixed build only)
//   grant_c     some request is pending
//   winner_c    port to serve when grant_c is high
module mem_port_arbiter_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic  if_re,
    input  logic  mm_req,
`ifdef ARB_RR_EN
    input  port_t last_port,
`else
    input  logic  starve_hit,
`endif
    output logic  grant_c,
    output port_t winner_c
);

    always_comb begin
        grant_c  = if_re | mm_req;
        winner_c = PORT_IF;
`ifdef ARB_RR_EN
        // On contention the port that did not win last time goes next.
        if (if_re && mm_req) begin
            winner_c = (last_port == PORT_IF) ? PORT_MM : PORT_IF;
        end else if (mm_req) begin
            winner_c = PORT_MM;
        end
`else
        // MEM wins unless IF is waiting and has been passed over too often.
        if (mm_req && !(if_re && starve_hit)) begin
            winner_c = PORT_MM;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the
// load/store stage; one outstanding transaction at a time.
// Config macro ARB_RR_EN: round-robin arbitration instead of fixed MEM
// priority with anti-starvation (starve counter compiled out).
// Ports:
//   clk, rst                  clock, async active-high reset
//   if_re/if_addr/if_rlen     IF read request (level, held until if_ack)
//   if_ack/if_rdata           IF completion pulse and returned word
//   mm_re/mm_we/mm_addr/...   MEM request (level, held until mm_ack)
//   mm_ack/mm_rdata           MEM completion pulse and load data
//   m_re/m_we/m_addr/...      registered strobe and payload to memory
//   m_rdata/m_ack             memory return data and completion pulse
//   err                       sticky: illegal length, re&we, or stray m_ack
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_L   = 32,
    parameter int unsigned DATA_L   = 32,
    parameter int unsigned STARVE_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_re,
    input  logic [ADDR_L-1:0] if_addr,
    input  logic [LEN_L-1:0]  if_rlen,
    output logic              if_ack,
    output logic [DATA_L-1:0] if_rdata,
    input  logic              mm_re,
    input  logic              mm_we,
    input  logic [ADDR_L-1:0] mm_addr,
    input  logic [LEN_L-1:0]  mm_len,
    input  logic [DATA_L-1:0] mm_wdata,
    output logic              mm_ack,
    output logic [DATA_L-1:0] mm_rdata,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_L-1:0] m_addr,
    output logic [LEN_L-1:0]  m_len,
    output logic [DATA_L-1:0] m_wdata,
    input  logic [DATA_L-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic              grant_c;
    port_t             winner_c;
    logic              m_re_d, m_we_d, if_ack_d, mm_ack_d, err_d;
    logic [ADDR_L-1:0] m_addr_d;
    logic [LEN_L-1:0]  m_len_d;
    logic [DATA_L-1:0] m_wdata_d, if_rdata_d, mm_rdata_d;

`ifdef ARB_RR_EN
    port_t last_q, last_d;
`else
    localparam int unsigned CNT_W = (STARVE_N < 1) ? 1 : $clog2(STARVE_N + 1);
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit_c;

    assign starve_hit_c = (starve_q >= CNT_W'(STARVE_N));
`endif

    mem_port_arbiter_pick u_pick (
        .if_re      (if_re),
        .mm_req     (mm_re | mm_we),
`ifdef ARB_RR_EN
        .last_port  (last_q),
`else
        .starve_hit (starve_hit_c),
`endif
        .grant_c    (grant_c),
        .winner_c   (winner_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        m_re_d     = m_re;
        m_we_d     = m_we;
        m_addr_d   = m_addr;
        m_len_d    = m_len;
        m_wdata_d  = m_wdata;
        if_ack_d   = 1'b0;
        mm_ack_d   = 1'b0;
        if_rdata_d = if_rdata;
        mm_rdata_d = mm_rdata;
        err_d      = err;
`ifdef ARB_RR_EN
        last_d     = last_q;
`else
        starve_d   = starve_q;
`endif

        case (state_q)
            ARB_IDLE: begin
                // No strobe is up yet, so any m_ack here is stray.
                if (m_ack) begin
                    err_d = 1'b1;
                end
                if (grant_c) begin
                    if (winner_c == PORT_MM) begin
                        state_d   = ARB_BUSY_MM;
                        m_we_d    = mm_we;
                        m_re_d    = ~mm_we;
                        m_addr_d  = mm_addr;
                        m_len_d   = mm_len;
                        m_wdata_d = mm_wdata;
                        if ((mm_re && mm_we) || len_illegal(mm_len)) begin
                            err_d = 1'b1;
                        end
`ifndef ARB_RR_EN
                        // Only grants that passed over a waiting IF count.
                        starve_d = if_re ? (starve_q + CNT_W'(1)) : '0;
`endif
                    end else begin
                        state_d  = ARB_BUSY_IF;
                        m_re_d   = 1'b1;
                        m_we_d   = 1'b0;
                        m_addr_d = if_addr;
                        m_len_d  = if_rlen;
                        if (len_illegal(if_rlen)) begin
                            err_d = 1'b1;
                        end
`ifndef ARB_RR_EN
                        starve_d = '0;
`endif
                    end
`ifdef ARB_RR_EN
                    last_d = winner_c;
`endif
                end
            end
            ARB_BUSY_IF: begin
                if (m_ack) begin
                    state_d    = ARB_DONE;
                    m_re_d     = 1'b0;
                    m_we_d     = 1'b0;
                    if_rdata_d = m_rdata;
                    if_ack_d   = 1'b1;
                end
            end
            ARB_BUSY_MM: begin
                if (m_ack) begin
                    state_d  = ARB_DONE;
                    m_re_d   = 1'b0;
                    m_we_d   = 1'b0;
                    mm_ack_d = 1'b1;
                    if (m_re) begin
                        mm_rdata_d = m_rdata;
                    end
                end
            end
            ARB_DONE: begin
                // Dead cycle lets the served requester drop its level.
                state_d = ARB_IDLE;
                if (m_ack) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            m_re     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_len    <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            mm_ack   <= 1'b0;
            if_rdata <= '0;
            mm_rdata <= '0;
            err      <= 1'b0;
`ifdef ARB_RR_EN
            last_q   <= PORT_IF;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            m_re     <= m_re_d;
            m_we     <= m_we_d;
            m_addr   <= m_addr_d;
            m_len    <= m_len_d;
            m_wdata  <= m_wdata_d;
            if_ack   <= if_ack_d;
            mm_ack   <= mm_ack_d;
            if_rdata <= if_rdata_d;
            mm_rdata <= mm_rdata_d;
            err      <= err_d;
`ifdef ARB_RR_EN
            last_q   <= last_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_re, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic [1:0]  if_rlen;
    logic        mm_re, mm_we, mm_ack;
    logic [31:0] mm_addr, mm_wdata, mm_rdata;
    logic [1:0]  mm_len;
    logic        m_re, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_len;
    logic        err;

    mem_port_arbiter #(.ADDR_L(32), .DATA_L(32), .STARVE_N(4)) dut (
        .clk(clk), .rst(rst),
        .if_re(if_re), .if_addr(if_addr), .if_rlen(if_rlen), .if_ack(if_ack), .if_rdata(if_rdata),
        .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .mm_len(mm_len), .mm_wdata(mm_wdata),
        .mm_ack(mm_ack), .mm_rdata(mm_rdata),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    typedef struct { logic re; logic we; logic [31:0] addr; logic [1:0] len; logic [31:0] wdata; } job_t;
    typedef struct { logic chk; logic [31:0] data; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [1:0] len; logic [31:0] wdata; } acc_t;
    typedef struct {
        logic is_mm; logic re; logic we; logic [31:0] addr; logic [1:0] len;
        logic [31:0] wdata; int lat; logic [31:0] exp_rdata;
    } vec_t;

    job_t        if_jobs[$], mm_jobs[$];
    exp_t        if_exp[$], mm_exp[$];
    acc_t        acc_q[$];
    bit          ack_log[$];
    logic [31:0] mem [logic [31:0]];
    int          ack_cnt = 0;
    int          mem_lat = 3;
    bit          stray_req = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory model: acks mem_lat cycles after a strobe, logs each access.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (stray_req) begin
                stray_req = 1'b0;
                m_ack = 1'b1;
                m_rdata = 32'h5A5A_5A5A;
            end else if (m_re || m_we) begin
                if (cnt >= mem_lat - 1) begin
                    cnt = 0;
                    m_ack = 1'b1;
                    acc_q.push_back('{we: m_we, addr: m_addr, len: m_len, wdata: m_wdata});
                    if (m_we) mem[m_addr] = m_wdata;
                    else m_rdata = mem.exists(m_addr) ? mem[m_addr] : ~m_addr;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // IF requester: holds if_re until if_ack, then takes the next job.
    initial begin : if_port
        job_t j;
        if_re = 1'b0; if_addr = '0; if_rlen = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if_re = 1'b0;
            end else if (if_re) begin
                if (if_ack) if_re = 1'b0;
            end else if (if_jobs.size() > 0) begin
                j = if_jobs.pop_front();
                if_re = 1'b1; if_addr = j.addr; if_rlen = j.len;
            end
        end
    end

    // MEM requester: same protocol for loads and stores.
    initial begin : mm_port
        job_t j;
        mm_re = 1'b0; mm_we = 1'b0; mm_addr = '0; mm_len = '0; mm_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mm_re = 1'b0; mm_we = 1'b0;
            end else if (mm_re || mm_we) begin
                if (mm_ack) begin mm_re = 1'b0; mm_we = 1'b0; end
            end else if (mm_jobs.size() > 0) begin
                j = mm_jobs.pop_front();
                mm_re = j.re; mm_we = j.we; mm_addr = j.addr; mm_len = j.len; mm_wdata = j.wdata;
            end
        end
    end

    // Scoreboard: pops the expected result whenever the DUT acks a port.
    initial begin : monitor
        exp_t e;
        logic prev_if, prev_mm;
        prev_if = 1'b0; prev_mm = 1'b0;
        forever begin
            @(negedge clk);
            if (if_ack) begin
                ack_cnt++;
                ack_log.push_back(1'b0);
                check("if_ack_width", 32'(prev_if), 32'd0);
                check("if_ack_expected", 32'(if_exp.size() != 0), 32'd1);
                if (if_exp.size() != 0) begin
                    e = if_exp.pop_front();
                    if (e.chk) check("if_rdata", if_rdata, e.data);
                end
            end
            if (mm_ack) begin
                ack_cnt++;
                ack_log.push_back(1'b1);
                check("mm_ack_width", 32'(prev_mm), 32'd0);
                check("mm_ack_expected", 32'(mm_exp.size() != 0), 32'd1);
                if (mm_exp.size() != 0) begin
                    e = mm_exp.pop_front();
                    if (e.chk) check("mm_rdata", mm_rdata, e.data);
                end
            end
            prev_if = if_ack;
            prev_mm = mm_ack;
        end
    end

    task automatic issue(input logic is_mm, input logic re, input logic we, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata, input logic chk,
                         input logic [31:0] exp_d);
        job_t j;
        exp_t e;
        j = '{re: re, we: we, addr: addr, len: len, wdata: wdata};
        e = '{chk: chk, data: exp_d};
        if (is_mm) begin mm_jobs.push_back(j); mm_exp.push_back(e); end
        else begin if_jobs.push_back(j); if_exp.push_back(e); end
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (ack_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_done"}, 32'(ack_cnt >= target), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_acc(input string name, input logic we, input logic [31:0] addr,
                             input logic [1:0] len, input logic [31:0] wdata);
        acc_t a;
        check({name, "_present"}, 32'(acc_q.size() != 0), 32'd1);
        if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            check({name, "_addr"}, a.addr, addr);
            check({name, "_we_len"}, {29'd0, a.we, a.len}, {29'd0, we, len});
            if (we) check({name, "_wdata"}, a.wdata, wdata);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin : main
        vec_t vt[8];
        bit   exp_order[9];
        int   base, lb, n, c_ack, c_if;

        rst = 1'b1;
        mem[32'h1000] = 32'h0000_0013;
        mem[32'h0100] = 32'h1111_0001;
        mem[32'h0104] = 32'h2222_0002;
        mem[32'h0200] = 32'h3333_0003;

        vt[0] = '{is_mm: 0, re: 1, we: 0, addr: 32'h100, len: 2'd3, wdata: 0, lat: 1, exp_rdata: 32'h1111_0001};
        vt[1] = '{is_mm: 0, re: 1, we: 0, addr: 32'h104, len: 2'd1, wdata: 0, lat: 2, exp_rdata: 32'h2222_0002};
        vt[2] = '{is_mm: 1, re: 1, we: 0, addr: 32'h200, len: 2'd0, wdata: 0, lat: 3, exp_rdata: 32'h3333_0003};
        vt[3] = '{is_mm: 1, re: 0, we: 1, addr: 32'h300, len: 2'd3, wdata: 32'hCAFE_F00D, lat: 4, exp_rdata: 0};
        vt[4] = '{is_mm: 1, re: 1, we: 0, addr: 32'h300, len: 2'd3, wdata: 0, lat: 1, exp_rdata: 32'hCAFE_F00D};
        vt[5] = '{is_mm: 0, re: 1, we: 0, addr: 32'h300, len: 2'd3, wdata: 0, lat: 2, exp_rdata: 32'hCAFE_F00D};
        vt[6] = '{is_mm: 1, re: 0, we: 1, addr: 32'h304, len: 2'd1, wdata: 32'h0000_BEEF, lat: 2, exp_rdata: 0};
        vt[7] = '{is_mm: 0, re: 1, we: 0, addr: 32'hFFFF_FFFC, len: 2'd3, wdata: 0, lat: 3, exp_rdata: 32'h0000_0003};

`ifdef ARB_RR_EN
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 1, 1};
`else
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
`endif

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_re", 32'(m_re), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_acks", {30'd0, if_ack, mm_ack}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mm_rdata", mm_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Single IF read: strobe one cycle after request, ack one cycle after m_ack
        mem_lat = 3;
        base = ack_cnt;
        issue(1'b0, 1'b1, 1'b0, 32'h1000, 2'd3, 32'd0, 1'b1, 32'h0000_0013);
        n = 0;
        while (!if_re && n < 10) begin @(negedge clk); #1; n++; end
        check("t1_if_re_up", 32'(if_re), 32'd1);
        check("t1_m_re_not_yet", 32'(m_re), 32'd0);
        @(negedge clk); #1;
        check("t1_m_re_latency", 32'(m_re), 32'd1);
        check("t1_m_addr", m_addr, 32'h1000);
        c_ack = -1; c_if = -1;
        for (int c = 0; c < 20; c++) begin
            if (m_ack && c_ack < 0) c_ack = c;
            if (if_ack && c_if < 0) c_if = c;
            @(negedge clk); #1;
        end
        check("t1_ack_spacing", 32'(c_if - c_ack), 32'd1);
        check("t1_if_rdata", if_rdata, 32'h0000_0013);
        check("t1_m_re_dropped", 32'(m_re), 32'd0);
        wait_acks(base + 1, 10, "t1");
        check_acc("t1_acc", 1'b0, 32'h1000, 2'd3, 32'd0);

        // Table of single transactions
        foreach (vt[i]) begin
            mem_lat = vt[i].lat;
            base = ack_cnt;
            issue(vt[i].is_mm, vt[i].re, vt[i].we, vt[i].addr, vt[i].len, vt[i].wdata, ~vt[i].we, vt[i].exp_rdata);
            wait_acks(base + 1, 40, $sformatf("vec%0d", i));
            check_acc($sformatf("vec%0d_acc", i), vt[i].we, vt[i].addr, vt[i].len, vt[i].wdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
        end

        // IF and MEM write in the same cycle: MEM goes first
        mem_lat = 2;
        base = ack_cnt;
        lb = ack_log.size();
        issue(1'b1, 1'b0, 1'b1, 32'h2000, 2'd3, 32'hDEAD_BEEF, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 32'h1000, 2'd3, 32'd0, 1'b1, 32'h0000_0013);
        wait_acks(base + 2, 60, "t2");
        check("t2_first_mm", 32'(ack_log[lb]), 32'd1);
        check("t2_second_if", 32'(ack_log[lb + 1]), 32'd0);
        check_acc("t2_mm_acc", 1'b1, 32'h2000, 2'd3, 32'hDEAD_BEEF);
        check_acc("t2_if_acc", 1'b0, 32'h1000, 2'd3, 32'd0);

        // Sustained contention: grant order shows priority / anti-starvation
        mem_lat = 1;
        base = ack_cnt;
        lb = ack_log.size();
        for (int k = 0; k < 6; k++)
            issue(1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * k), 2'd3, 32'd0, 1'b1, ~(32'h400 + 32'(4 * k)));
        for (int k = 0; k < 3; k++)
            issue(1'b0, 1'b1, 1'b0, 32'h500 + 32'(4 * k), 2'd3, 32'd0, 1'b1, ~(32'h500 + 32'(4 * k)));
        wait_acks(base + 9, 200, "t3");
        for (int k = 0; k < 9; k++)
            check($sformatf("t3_order%0d", k), 32'(ack_log[lb + k]), 32'(exp_order[k]));
        acc_q.delete();

        // Stray m_ack in IDLE sets err without touching read data
        check("t4_err_clear", 32'(err), 32'd0);
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t4_err_stray", 32'(err), 32'd1);
        check("t4_if_rdata_hold", if_rdata, ~32'h508);
        check("t4_mm_rdata_hold", mm_rdata, ~32'h414);
        base = ack_cnt;
        issue(1'b1, 1'b1, 1'b0, 32'h600, 2'd2, 32'd0, 1'b1, ~32'h600);
        wait_acks(base + 1, 40, "t4_len2");
        check_acc("t4_len2_acc", 1'b0, 32'h600, 2'd2, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("t4_err_sticky", 32'(err), 32'd1);

        // Illegal length alone, then re&we together, each from a clean reset
        do_reset();
        check("t4_err_after_rst", 32'(err), 32'd0);
        base = ack_cnt;
        issue(1'b1, 1'b1, 1'b0, 32'h640, 2'd2, 32'd0, 1'b1, ~32'h640);
        wait_acks(base + 1, 40, "t4_len2b");
        check_acc("t4_len2b_acc", 1'b0, 32'h640, 2'd2, 32'd0);
        check("t4_err_len2", 32'(err), 32'd1);
        do_reset();
        base = ack_cnt;
        issue(1'b1, 1'b1, 1'b1, 32'h700, 2'd3, 32'h1234_5678, 1'b0, 32'd0);
        wait_acks(base + 1, 40, "t4_rewe");
        check_acc("t4_rewe_acc", 1'b1, 32'h700, 2'd3, 32'h1234_5678);
        check("t4_err_rewe", 32'(err), 32'd1);

        // Reset during an in-flight store: strobe drops at once, no ack
        do_reset();
        mem_lat = 10;
        issue(1'b1, 1'b0, 1'b1, 32'h800, 2'd3, 32'hA5A5_A5A5, 1'b0, 32'd0);
        n = 0;
        while (!m_we && n < 10) begin @(negedge clk); #1; n++; end
        check("t5_m_we_up", 32'(m_we), 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_m_we_async_clear", 32'(m_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mm_exp.delete();
        base = ack_cnt;
        repeat (12) @(negedge clk);
        #1;
        check("t5_no_mm_ack", 32'(ack_cnt - base), 32'd0);
        check("t5_no_access", 32'(acc_q.size()), 32'd0);
        mem_lat = 2;
        issue(1'b0, 1'b1, 1'b0, 32'h1000, 2'd3, 32'd0, 1'b1, 32'h0000_0013);
        wait_acks(base + 1, 40, "t5_if");
        check_acc("t5_if_acc", 1'b0, 32'h1000, 2'd3, 32'd0);
        check("t5_if_rdata", if_rdata, 32'h0000_0013);

        // Nothing left unconsumed
        check("sb_if_empty", 32'(if_exp.size()), 32'd0);
        check("sb_mm_empty", 32'(mm_exp.size()), 32'd0);
        check("sb_acc_empty", 32'(acc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
